// File: rtl/pkt_frame_tx.sv
// pkt_frame_tx - framed-stream packet transmitter.
//
// Sends each accepted request as one head beat (the header word), then LEN
// payload words pulled from an upstream source, then one tail beat carrying
// the XOR checksum of those payload words.
//
// Ports:
//   clk       clock; all state changes on the rising edge
//   reset     asynchronous, active-low reset
//   start     send request; taken only while ready=1
//   len       payload word count, sampled on accept
//   hdr       header word, sampled on accept
//   ready     combinational; high in IDLE and TAIL
//   pl_valid  upstream payload word available
//   pl_data   upstream payload word
//   pl_pop    combinational; payload word consumed this cycle
//   tx_valid  registered beat valid
//   tx_head   registered head-beat marker
//   tx_tail   registered tail-beat marker
//   tx_data   registered beat payload (header, data word or checksum)
//   done      registered; high together with the tail beat
//   state     current beat type: IDLE=00, HEAD=01, DATA=10, TAIL=11
module pkt_frame_tx #(
  parameter int DW    = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [DW-1:0]    hdr,
  output logic             ready,
  input  logic             pl_valid,
  input  logic [DW-1:0]    pl_data,
  output logic             pl_pop,
  output logic             tx_valid,
  output logic             tx_head,
  output logic             tx_tail,
  output logic [DW-1:0]    tx_data,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    DATA = 2'b10,
    TAIL = 2'b11
  } state_t;

  state_t           st;
  logic [LEN_W-1:0] remaining;
  logic [DW-1:0]    csum;
  logic             in_body;

  // Running checksum: plain bitwise XOR, so no carries and no growth.
  function automatic logic [DW-1:0] csum_fold(input logic [DW-1:0] acc,
                                              input logic [DW-1:0] word);
    return acc ^ word;
  endfunction

  // The state register mirrors the beat type on the outputs, so HEAD and
  // DATA are exactly the cycles in which payload may still be pulled.
  assign in_body = (st == HEAD) || (st == DATA);
  assign ready   = (st == IDLE) || (st == TAIL);
  assign pl_pop  = pl_valid && in_body && (remaining != '0);
  assign state   = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      remaining <= '0;
      csum      <= '0;
      tx_valid  <= 1'b0;
      tx_head   <= 1'b0;
      tx_tail   <= 1'b0;
      tx_data   <= '0;
      done      <= 1'b0;
    end else begin
      // Every beat is a single-cycle pulse; cycles that emit nothing
      // register all-zero outputs.
      tx_valid <= 1'b0;
      tx_head  <= 1'b0;
      tx_tail  <= 1'b0;
      tx_data  <= '0;
      done     <= 1'b0;

      case (st)
        IDLE, TAIL: begin
          // TAIL accepts a new request directly, giving back-to-back packets.
          if (start) begin
            st        <= HEAD;
            remaining <= len;
            csum      <= '0;
            tx_valid  <= 1'b1;
            tx_head   <= 1'b1;
            tx_data   <= hdr;
          end else begin
            st <= IDLE;
          end
        end

        HEAD, DATA: begin
          if (remaining != '0) begin
            // A missing payload word becomes a DATA-state bubble.
            st <= DATA;
            if (pl_valid) begin
              tx_valid  <= 1'b1;
              tx_data   <= pl_data;
              remaining <= remaining - 1'b1;
              csum      <= csum_fold(csum, pl_data);
            end
          end else begin
            st       <= TAIL;
            tx_valid <= 1'b1;
            tx_tail  <= 1'b1;
            tx_data  <= csum;
            done     <= 1'b1;
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_frame_tx.sv
module tb_pkt_frame_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic [7:0] hdr;
  logic       ready;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_pop;
  logic       tx_valid;
  logic       tx_head;
  logic       tx_tail;
  logic [7:0] tx_data;
  logic       done;
  logic [1:0] state;

  int passed = 0;
  int total  = 0;
  int pops   = 0;
  logic [13:0] e;

  pkt_frame_tx #(.DW(8), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .hdr(hdr),
    .ready(ready), .pl_valid(pl_valid), .pl_data(pl_data), .pl_pop(pl_pop),
    .tx_valid(tx_valid), .tx_head(tx_head), .tx_tail(tx_tail),
    .tx_data(tx_data), .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {state, valid, head, tail, done, data}.
  function automatic logic [13:0] bt(input logic [1:0] s, input logic v,
                                     input logic h, input logic t,
                                     input logic d, input logic [7:0] dat);
    return {s, v, h, t, d, dat};
  endfunction

  function automatic logic [13:0] cur();
    return {state, tx_valid, tx_head, tx_tail, done, tx_data};
  endfunction

  // Called 1 time unit after a rising edge; counts a pop just before the
  // next edge, then returns 1 time unit after that edge.
  task automatic tick();
    #3;
    if (pl_pop === 1'b1) pops++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    e = bt(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (cur() !== e) $display("FAIL reset_outputs got=%h exp=%h", cur(), e); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else passed++;
    total++; if (pl_pop !== 1'b0) $display("FAIL reset_pop got=%b exp=0", pl_pop); else passed++;
  endtask

  task automatic test_basic();
    pops = 0;
    e = bt(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (cur() !== e) $display("FAIL basic_idle got=%h exp=%h", cur(), e); else passed++;
    hdr = 8'hA5; len = 4'd2; start = 1'b1; pl_valid = 1'b1; pl_data = 8'h11;
    tick(); start = 1'b0;
    e = bt(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    total++; if (cur() !== e) $display("FAIL basic_head got=%h exp=%h", cur(), e); else passed++;
    tick(); pl_data = 8'h22;
    e = bt(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    total++; if (cur() !== e) $display("FAIL basic_data0 got=%h exp=%h", cur(), e); else passed++;
    tick();
    e = bt(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
    total++; if (cur() !== e) $display("FAIL basic_data1 got=%h exp=%h", cur(), e); else passed++;
    tick();
    e = bt(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33);
    total++; if (cur() !== e) $display("FAIL basic_tail got=%h exp=%h", cur(), e); else passed++;
    tick(); pl_valid = 1'b0;
    e = bt(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (cur() !== e) $display("FAIL basic_idle_after got=%h exp=%h", cur(), e); else passed++;
    total++; if (pops !== 2) $display("FAIL basic_pops got=%0d exp=2", pops); else passed++;
  endtask

  task automatic test_len_zero();
    pops = 0;
    hdr = 8'h3C; len = 4'd0; start = 1'b1; pl_valid = 1'b1; pl_data = 8'hFF;
    tick(); start = 1'b0;
    e = bt(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
    total++; if (cur() !== e) $display("FAIL len0_head got=%h exp=%h", cur(), e); else passed++;
    tick();
    e = bt(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    total++; if (cur() !== e) $display("FAIL len0_tail got=%h exp=%h", cur(), e); else passed++;
    tick(); pl_valid = 1'b0;
    e = bt(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (cur() !== e) $display("FAIL len0_idle got=%h exp=%h", cur(), e); else passed++;
    total++; if (pops !== 0) $display("FAIL len0_pops got=%0d exp=0", pops); else passed++;
  endtask

  task automatic test_stall();
    pops = 0;
    hdr = 8'hC3; len = 4'd1; start = 1'b1; pl_valid = 1'b0; pl_data = 8'h00;
    tick(); start = 1'b0;
    e = bt(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
    total++; if (cur() !== e) $display("FAIL stall_head got=%h exp=%h", cur(), e); else passed++;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = bt(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      total++; if (cur() !== e) $display("FAIL stall_bubble%0d got=%h exp=%h", i, cur(), e); else passed++;
    end
    pl_valid = 1'b1; pl_data = 8'h7E;
    tick(); pl_valid = 1'b0;
    e = bt(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7E);
    total++; if (cur() !== e) $display("FAIL stall_data got=%h exp=%h", cur(), e); else passed++;
    tick();
    e = bt(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h7E);
    total++; if (cur() !== e) $display("FAIL stall_tail got=%h exp=%h", cur(), e); else passed++;
    tick();
    total++; if (pops !== 1) $display("FAIL stall_pops got=%0d exp=1", pops); else passed++;
  endtask

  task automatic test_back_to_back();
    pops = 0;
    hdr = 8'h12; len = 4'd1; start = 1'b1; pl_valid = 1'b1; pl_data = 8'h40;
    tick();
    e = bt(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12);
    total++; if (cur() !== e) $display("FAIL b2b_head1 got=%h exp=%h", cur(), e); else passed++;
    tick(); hdr = 8'h5A; len = 4'd1; pl_data = 8'h01;
    e = bt(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40);
    total++; if (cur() !== e) $display("FAIL b2b_data1 got=%h exp=%h", cur(), e); else passed++;
    tick();
    e = bt(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40);
    total++; if (cur() !== e) $display("FAIL b2b_tail1 got=%h exp=%h", cur(), e); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL b2b_ready_tail got=%b exp=1", ready); else passed++;
    tick(); start = 1'b0;
    e = bt(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    total++; if (cur() !== e) $display("FAIL b2b_head2 got=%h exp=%h", cur(), e); else passed++;
    tick();
    e = bt(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    total++; if (cur() !== e) $display("FAIL b2b_data2 got=%h exp=%h", cur(), e); else passed++;
    tick(); pl_valid = 1'b0;
    e = bt(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01);
    total++; if (cur() !== e) $display("FAIL b2b_tail2 got=%h exp=%h", cur(), e); else passed++;
    tick();
    e = bt(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (cur() !== e) $display("FAIL b2b_idle got=%h exp=%h", cur(), e); else passed++;
    total++; if (pops !== 2) $display("FAIL b2b_pops got=%0d exp=2", pops); else passed++;
  endtask

  task automatic test_reset_mid();
    hdr = 8'h99; len = 4'd3; start = 1'b1; pl_valid = 1'b1; pl_data = 8'hF0;
    tick(); start = 1'b0;
    tick(); pl_data = 8'h0F;
    e = bt(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0);
    total++; if (cur() !== e) $display("FAIL rstmid_data got=%h exp=%h", cur(), e); else passed++;
    // Assert reset between edges: outputs must clear without a clock.
    #3 reset = 1'b0;
    #1;
    e = bt(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (cur() !== e) $display("FAIL rstmid_async got=%h exp=%h", cur(), e); else passed++;
    total++; if (pl_pop !== 1'b0) $display("FAIL rstmid_pop got=%b exp=0", pl_pop); else passed++;
    @(posedge clk); #1;
    total++; if (cur() !== e) $display("FAIL rstmid_no_tail got=%h exp=%h", cur(), e); else passed++;
    reset = 1'b1;
    pops = 0;
    hdr = 8'hAB; len = 4'd1; start = 1'b1; pl_data = 8'h55;
    tick(); start = 1'b0;
    e = bt(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAB);
    total++; if (cur() !== e) $display("FAIL rstmid_head got=%h exp=%h", cur(), e); else passed++;
    tick();
    e = bt(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    total++; if (cur() !== e) $display("FAIL rstmid_data2 got=%h exp=%h", cur(), e); else passed++;
    tick(); pl_valid = 1'b0;
    e = bt(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
    total++; if (cur() !== e) $display("FAIL rstmid_tail got=%h exp=%h", cur(), e); else passed++;
    tick();
    total++; if (pops !== 1) $display("FAIL rstmid_pops got=%0d exp=1", pops); else passed++;
  endtask

  task automatic test_ignored_start();
    hdr = 8'h21; len = 4'd2; start = 1'b1; pl_valid = 1'b1; pl_data = 8'h03;
    tick(); start = 1'b0;
    tick(); pl_data = 8'h0C;
    e = bt(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    total++; if (cur() !== e) $display("FAIL ign_data0 got=%h exp=%h", cur(), e); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL ign_ready got=%b exp=0", ready); else passed++;
    hdr = 8'hEE; len = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    e = bt(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0C);
    total++; if (cur() !== e) $display("FAIL ign_data1 got=%h exp=%h", cur(), e); else passed++;
    tick(); pl_valid = 1'b0;
    e = bt(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F);
    total++; if (cur() !== e) $display("FAIL ign_tail got=%h exp=%h", cur(), e); else passed++;
    tick();
    e = bt(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (cur() !== e) $display("FAIL ign_idle got=%h exp=%h", cur(), e); else passed++;
    tick();
    total++; if (cur() !== e) $display("FAIL ign_idle_hold got=%h exp=%h", cur(), e); else passed++;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; len = 4'd0; hdr = 8'h00;
    pl_valid = 1'b0; pl_data = 8'h00;
    #12;
    test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_len_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_ignored_start();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pkt_frame_tx.md
Name: pkt_frame_tx

Overview:
- Packet framing transmitter: the sending end of the valid/head/tail framed stream whose receiver FSM tracks the IDLE/HEAD/DATA/TAIL states.
- Accepts a send request carrying a header word and a payload length.
- Pulls payload words from an upstream source and emits, in order: one head beat, LEN data beats, and one tail beat carrying an XOR checksum.
- Sits between a packet buffer and the framed link; it drives every transition the receiver FSM covers, including IDLE->IDLE, HEAD->TAIL, DATA->DATA, TAIL->HEAD and TAIL->IDLE.

Parameters:
- DW, 8, data/header/checksum width in bits.
- LEN_W, 4, width of the payload length field; maximum payload is 2**LEN_W-1 words.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  send request; accepted only when ready=1.
- len  input  LEN_W  payload word count for the request, sampled on accept.
- hdr  input  DW  header word for the request, sampled on accept.
- ready  output  1  combinational; 1 in IDLE and TAIL states.
- pl_valid  input  1  upstream payload word available.
- pl_data  input  DW  upstream payload word.
- pl_pop  output  1  combinational; payload word consumed this cycle.
- tx_valid  output  1  registered; beat valid.
- tx_head  output  1  registered; head beat marker.
- tx_tail  output  1  registered; tail beat marker.
- tx_data  output  DW  registered; beat payload.
- done  output  1  registered; high exactly with the tail beat.
- state  output  2  current FSM state: IDLE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - tx_valid, tx_head, tx_tail, done, tx_data = 0.
  - Internal remaining count and csum = 0.
  - Reset mid-packet abandons the packet immediately: no tail is emitted, and no pl_pop occurs until after reset deasserts.
- State encoding: state equals the beat type currently on the tx_* outputs (DATA also covers stall bubbles).
- Registered-output defaults: any cycle not listed below registers tx_valid=0, tx_head=0, tx_tail=0, done=0, tx_data=0.
- Request accept: on a rising edge with start=1 and ready=1:
  - Load remaining=len and set csum=0.
  - Next state HEAD, with tx_valid=1, tx_head=1, tx_data=hdr.
  - Latency from start to head beat: 1 clock.
- Ignored requests: start while ready=0 is ignored (not queued); the requester must hold start.
- pl_pop = pl_valid & (state==HEAD | state==DATA) & (remaining!=0).
- HEAD or DATA, remaining!=0, pl_valid=1:
  - pop the word.
  - Next state DATA; tx_valid=1, tx_data=pl_data.
  - remaining decrements by 1; csum ^= pl_data.
- HEAD or DATA, remaining!=0, pl_valid=0:
  - Next state DATA; tx_valid=0 (bubble).
  - remaining and csum are held.
- HEAD or DATA, remaining==0:
  - Next state TAIL; tx_valid=1, tx_tail=1, done=1, tx_data=csum (includes the final word).
  - len=0 therefore produces HEAD then TAIL on consecutive cycles, with tx_data=0 on the tail.
- TAIL:
  - If start=1: accept the request and go to HEAD (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- IDLE: stays IDLE (tx_valid=0) until start.
- Marker exclusivity: tx_head and tx_tail are never both 1; tx_head/tx_tail are only ever 1 when tx_valid=1.
- Width rules: remaining is LEN_W bits and never underflows; csum is DW bits (bitwise XOR, no carries).

Test Plan:
- DW=8, hdr=0xA5, len=2, pl_valid=1 with words 0x11,0x22 -> beats head A5, data 11, data 22, tail 33 with done=1; state 00->01->10->10->11->00; exactly 2 pl_pop pulses.
- len=0, hdr=0x3C -> head 3C then tail 00 on the next cycle; state 01->11 (HEAD->TAIL); zero pl_pop.
- len=1, pl_valid=0 for 2 cycles after head, then 0x7E -> two tx_valid=0 bubbles with state=10, then data 7E, then tail 7E.
- start held high through the first tail; second packet hdr=0x5A, len=1, word 0x01 -> the cycle after the tail carries head 5A (TAIL->HEAD, no IDLE); second tail = 01.
- reset pulsed low during DATA of a len=3 packet -> outputs clear asynchronously, state=00, no tail beat; a following len=1 packet frames correctly with csum restarted from 0.
- start pulsed while state=DATA -> ignored; no head beat appears after the current tail; the FSM returns to IDLE.
